audio_fifo_write_sched: RTL and testbench
=========================================

// Module: audio_fifo_write_sched
// PURPOSE
//   Paces audio samples from the sample source (DDS/modulator) into the audio2fifo
//   write-side FIFO. Primes the FIFO at full speed on start, then writes exactly one
//   sample per div_freq clocks. Honours pause/stop from the CPU, blocks on FIFO level,
//   and counts underruns and dropped sample slots for software.
// PARAMETERS
//   DATA_W    32    sample width
//   USED_W    12    width of fifo_used
//   HIGH_WM   4032  fifo_used level at/above which writes are blocked (margin for 1-cycle lag)
//   PRIME_LVL 2048  fifo_used level that ends priming
//   CNT_W     16    width of status counters (saturating)
// PORTS
//   clk          in   1       system clock; single clock domain
//   reset        in   1       synchronous, active-high
//   enable       in   1       1 = playback requested
//   stop         in   1       abort playback (audio2fifo out_stop)
//   pause        in   1       freeze playback (audio2fifo out_pause)
//   div_freq     in   32      sample period in clk cycles; values <2 treated as 2
//   clr_stats    in   1       1-cycle pulse: clear underrun_cnt/drop_cnt
//   src_data     in   DATA_W  sample from source
//   src_valid    in   1       source has a sample
//   src_ready    out  1       combinational; handshake = src_valid & src_ready
//   fifo_full    in   1       FIFO full flag
//   fifo_used    in   USED_W  FIFO fill level
//   fifo_wrreq   out  1       registered write strobe
//   fifo_data    out  DATA_W  registered write data
//   state        out  2       0 IDLE, 1 PRIME, 2 RUN, 3 PAUSE
//   tick         out  1       registered 1-cycle pulse at each sample slot
//   underrun_cnt out  CNT_W   slots missed for lack of source data
//   drop_cnt     out  CNT_W   slots missed because FIFO blocked
// BEHAVIOUR
//   Reset: state=IDLE; fifo_wrreq, fifo_data, tick, counters, divider, pending = 0.
//   blocked = fifo_full | (fifo_used >= HIGH_WM) | pause.
//   src_ready = (state==PRIME & ~blocked) | (state==RUN & pending & ~blocked); else 0.
//   Write latency: handshake in cycle N -> fifo_wrreq=1, fifo_data=src_data in N+1.
//     A handshake always yields its write, even if stop/enable drop in N+1.
//   Transition priority: reset > (stop | ~enable) > pause > level/normal.
//   IDLE : enable & ~stop -> PRIME. Divider=0, pending=0.
//   PRIME: write every handshake; on fifo_used >= PRIME_LVL -> RUN with divider=0,
//          pending=0. Pause only blocks writes; state stays PRIME.
//   RUN  : divider counts 0..P-1, P = max(div_freq,2) latched at entry and at each
//          wrap (mid-period div_freq changes apply next period). At divider==P-1:
//          tick=1 next cycle, divider->0, pending->1. Handshake clears pending unless
//          it coincides with a slot (then pending stays 1 for the new slot).
//          Slot while pending=1 and no handshake that cycle: blocked -> drop_cnt+1,
//          else underrun_cnt+1; pending stays 1 (at most one owed sample).
//          pause -> PAUSE.
//   PAUSE: divider and pending frozen, src_ready=0, no ticks; ~pause -> RUN resuming
//          the same count.
//   stop | ~enable from any state -> IDLE next cycle; divider/pending cleared.
//   Counters saturate at all-ones; persist across stop; clear on reset or clr_stats
//     (clr_stats wins over a simultaneous increment).
// TESTING
//   1 enable=1, src_valid=1, fifo_used ramps 0->2048 -> wrreq every cycle, state PRIME->RUN
//     the cycle after used reaches 2048.
//   2 RUN, div_freq=100, src_valid=1, used=2500 -> exactly one wrreq per 100 clk;
//     tick period 100; counters stay 0.
//   3 RUN, src_valid=0 for 3 slots -> underrun_cnt=2 (first slot only sets pending),
//     then src_valid=1 -> one write at once, pending cleared.
//   4 RUN, fifo_used=4032 for 5 slots -> no wrreq, drop_cnt=4; used falls -> owed
//     sample written.
//   5 pause mid-period at divider=40 for 1000 clk -> no writes/ticks; release ->
//     next tick 59 clk later (div_freq=100).
//   6 stop asserted in same cycle as handshake -> that wrreq still issued, state IDLE,
//     no further writes; div_freq=0/1 -> period 2.

Source files
------------

// File: rtl/audio_fifo_write_sched.sv
// Paces source samples into the audio FIFO: fills it at full rate while priming, then writes one sample per period.
// Keeps saturating counts of sample slots missed because the source was empty or the FIFO was blocked.
module audio_fifo_write_sched #(
  parameter int DATA_W    = 32,
  parameter int USED_W    = 12,
  parameter int HIGH_WM   = 4032,
  parameter int PRIME_LVL = 2048,
  parameter int CNT_W     = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              stop,
  input  logic              pause,
  input  logic [31:0]       div_freq,
  input  logic              clr_stats,
  input  logic [DATA_W-1:0] src_data,
  input  logic              src_valid,
  output logic              src_ready,
  input  logic              fifo_full,
  input  logic [USED_W-1:0] fifo_used,
  output logic              fifo_wrreq,
  output logic [DATA_W-1:0] fifo_data,
  output logic [1:0]        state,
  output logic              tick,
  output logic [CNT_W-1:0]  underrun_cnt,
  output logic [CNT_W-1:0]  drop_cnt
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PRIME = 2'd1,
    S_RUN   = 2'd2,
    S_PAUSE = 2'd3
  } state_t;

  localparam logic [USED_W-1:0] HIGH_LVL  = USED_W'(HIGH_WM);
  localparam logic [USED_W-1:0] PRIME_THR = USED_W'(PRIME_LVL);

  state_t      cur_state, nxt_state;
  logic [31:0] divider, divider_nxt;
  logic [31:0] period, period_nxt;
  logic        pending, pending_nxt;
  logic        tick_nxt;
  logic        underrun_inc, drop_inc;
  logic        counting;
  logic        blocked;
  logic        handshake;
  logic        slot;
  logic [31:0] period_in;

  assign blocked   = fifo_full | (fifo_used >= HIGH_LVL) | pause;
  assign src_ready = ((cur_state == S_PRIME) & ~blocked) |
                     ((cur_state == S_RUN) & pending & ~blocked);
  assign handshake = src_valid & src_ready;
  assign period_in = (div_freq < 32'd2) ? 32'd2 : div_freq;
  assign slot      = (divider == period - 32'd1);
  assign state     = cur_state;

  always_comb begin
    nxt_state    = cur_state;
    divider_nxt  = divider;
    period_nxt   = period;
    pending_nxt  = pending;
    tick_nxt     = 1'b0;
    underrun_inc = 1'b0;
    drop_inc     = 1'b0;
    counting     = 1'b0;

    if (stop | ~enable) begin
      nxt_state   = S_IDLE;
      divider_nxt = 32'd0;
      pending_nxt = 1'b0;
    end else begin
      case (cur_state)
        S_IDLE: begin
          nxt_state   = S_PRIME;
          divider_nxt = 32'd0;
          pending_nxt = 1'b0;
        end
        S_PRIME: begin
          if (!pause && (fifo_used >= PRIME_THR)) begin
            nxt_state   = S_RUN;
            divider_nxt = 32'd0;
            pending_nxt = 1'b0;
            period_nxt  = period_in;
          end
        end
        S_RUN: begin
          if (pause) nxt_state = S_PAUSE;
          else       counting  = 1'b1;
        end
        S_PAUSE: begin
          // Release cycle already counts, so playback resumes without losing a clock.
          if (!pause) begin
            nxt_state = S_RUN;
            counting  = 1'b1;
          end
        end
        default: nxt_state = S_IDLE;
      endcase
    end

    if (counting) begin
      if (slot) begin
        divider_nxt = 32'd0;
        period_nxt  = period_in;
        tick_nxt    = 1'b1;
        pending_nxt = 1'b1;
        // A still-owed sample at a new slot means one slot is lost; at most one stays owed.
        if (pending && !handshake) begin
          if (blocked) drop_inc     = 1'b1;
          else         underrun_inc = 1'b1;
        end
      end else begin
        divider_nxt = divider + 32'd1;
        if (handshake) pending_nxt = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cur_state  <= S_IDLE;
      divider    <= 32'd0;
      period     <= 32'd2;
      pending    <= 1'b0;
      tick       <= 1'b0;
      fifo_wrreq <= 1'b0;
      fifo_data  <= '0;
    end else begin
      cur_state  <= nxt_state;
      divider    <= divider_nxt;
      period     <= period_nxt;
      pending    <= pending_nxt;
      tick       <= tick_nxt;
      fifo_wrreq <= handshake;
      if (handshake) fifo_data <= src_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || clr_stats) begin
      underrun_cnt <= '0;
      drop_cnt     <= '0;
    end else begin
      if (underrun_inc && !(&underrun_cnt)) underrun_cnt <= underrun_cnt + CNT_W'(1);
      if (drop_inc && !(&drop_cnt))         drop_cnt     <= drop_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_audio_fifo_write_sched.sv
// Bench for audio_fifo_write_sched: directed playback scenarios plus random traffic,
// compared against a slot-level behavioural model and a write-data scoreboard.
module tb_audio_fifo_write_sched;

  logic        clk = 1'b0;
  logic        reset, enable, stop, pause, clr_stats, src_valid, fifo_full;
  logic [31:0] div_freq, src_data;
  logic [11:0] fifo_used;
  logic        src_ready, fifo_wrreq, tick;
  logic [31:0] fifo_data;
  logic [1:0]  state;
  logic [15:0] underrun_cnt, drop_cnt;

  audio_fifo_write_sched dut (
    .clk(clk), .reset(reset), .enable(enable), .stop(stop), .pause(pause),
    .div_freq(div_freq), .clr_stats(clr_stats), .src_data(src_data),
    .src_valid(src_valid), .src_ready(src_ready), .fifo_full(fifo_full),
    .fifo_used(fifo_used), .fifo_wrreq(fifo_wrreq), .fifo_data(fifo_data),
    .state(state), .tick(tick), .underrun_cnt(underrun_cnt), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_q[$];

  // model: 0 idle, 1 prime, 2 run, 3 pause; elapsed = clocks spent in the current period
  int ms = 0, elapsed = 0, per = 2;
  bit owed = 0, m_ready = 0, exp_tick = 0, exp_wr = 0;
  int m_unr = 0, m_drop = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic model_cycle();
    bit blk, hs, advance;
    blk     = fifo_full || (fifo_used >= 12'd4032) || pause;
    m_ready = (ms == 1 && !blk) || (ms == 2 && owed && !blk);
    hs      = src_valid && m_ready;
    exp_tick = 0;
    advance  = 0;
    if (reset) begin
      ms = 0; elapsed = 0; owed = 0; m_unr = 0; m_drop = 0; exp_wr = 0;
      m_ready = 0;
    end else begin
      exp_wr = hs;
      if (hs) exp_q.push_back(src_data);
      if (stop || !enable) begin
        ms = 0; elapsed = 0; owed = 0;
      end else if (ms == 0) begin
        ms = 1; elapsed = 0; owed = 0;
      end else if (ms == 1) begin
        if (!pause && fifo_used >= 12'd2048) begin
          ms = 2; elapsed = 0; owed = 0;
          per = (div_freq < 2) ? 2 : int'(div_freq);
        end
      end else if (ms == 2) begin
        if (pause) ms = 3; else advance = 1;
      end else begin
        if (!pause) begin ms = 2; advance = 1; end
      end
      if (advance) begin
        elapsed++;
        if (elapsed == per) begin
          elapsed = 0;
          exp_tick = 1;
          per = (div_freq < 2) ? 2 : int'(div_freq);
          if (owed && !hs) begin
            if (blk) begin if (m_drop < 65535) m_drop++; end
            else     begin if (m_unr < 65535)  m_unr++;  end
          end
          owed = 1;
        end else if (hs) begin
          owed = 0;
        end
      end
      if (clr_stats) begin m_unr = 0; m_drop = 0; end
    end
  endtask

  // Inputs are set at a falling edge; one call advances one clock.
  task automatic step();
    #1;
    model_cycle();
    chk("src_ready", src_ready, m_ready);
    @(posedge clk);
    @(negedge clk);
    chk("state", state, ms);
    chk("tick", tick, exp_tick);
    chk("wrreq", fifo_wrreq, exp_wr);
    chk("underrun_cnt", underrun_cnt, m_unr);
    chk("drop_cnt", drop_cnt, m_drop);
  endtask

  task automatic wait_tick(input string nm, input int lim, output int n);
    n = 0;
    do begin
      src_data = $urandom;
      step();
      n++;
    end while (!tick && n < lim);
    if (!tick) begin
      checks++;
      errors++;
      $display("FAIL %s: no tick within %0d cycles", nm, lim);
    end
  endtask

  // Scoreboard monitor: every FIFO write must carry the oldest accepted sample.
  always @(negedge clk) begin
    if (fifo_wrreq) begin
      if (exp_q.size() == 0) chk("unexpected_write", 1, 0);
      else                   chk("write_data", fifo_data, exp_q.pop_front());
    end
  end

  initial begin
    int n;
    reset = 1; enable = 0; stop = 0; pause = 0; clr_stats = 0;
    src_valid = 0; fifo_full = 0; div_freq = 100; src_data = 0; fifo_used = 0;
    @(negedge clk);
    repeat (3) step();
    chk("rst_state", state, 0);
    chk("rst_wrreq", fifo_wrreq, 0);
    chk("rst_tick", tick, 0);
    chk("rst_underrun", underrun_cnt, 0);
    chk("rst_drop", drop_cnt, 0);
    reset = 0;

    // Priming at full rate while the level ramps up
    enable = 1; src_valid = 1;
    step();
    for (int i = 1; i <= 128; i++) begin
      src_data  = $urandom;
      fifo_used = 12'(i * 16);
      step();
      if (i == 127) chk("still_prime", state, 1);
    end
    chk("prime_to_run", state, 2);
    fifo_used = 12'd2500;

    // Steady run: one tick per 100 clocks
    wait_tick("run_first", 300, n);
    for (int k = 0; k < 5; k++) begin
      wait_tick("run_period", 300, n);
      chk("tick_period", n, 100);
    end
    chk("run_underrun", underrun_cnt, 0);
    chk("run_drop", drop_cnt, 0);

    // Source starved for three slots
    wait_tick("starve_align", 300, n);
    step();
    src_valid = 0;
    repeat (300) begin src_data = $urandom; step(); end
    chk("starve_underrun", underrun_cnt, 2);
    src_valid = 1; src_data = $urandom;
    step();
    chk("owed_written", fifo_wrreq, 1);

    // FIFO at the high watermark for five slots
    wait_tick("block_align", 300, n);
    step();
    fifo_used = 12'd4032;
    repeat (500) begin src_data = $urandom; step(); end
    chk("block_drop", drop_cnt, 4);
    fifo_used = 12'd2500; src_data = $urandom;
    step();
    chk("blocked_owed_written", fifo_wrreq, 1);

    // Pause in the middle of a period
    n = 0;
    while (!(ms == 2 && elapsed == 40) && n < 300) begin src_data = $urandom; step(); n++; end
    chk("pause_align", elapsed, 40);
    pause = 1;
    repeat (1000) begin src_data = $urandom; step(); end
    pause = 0;
    step();
    chk("resumed", state, 2);
    wait_tick("pause_resume", 300, n);
    chk("resume_to_tick", n, 59);

    // Stop coinciding with a handshake
    wait_tick("stop_align", 300, n);
    stop = 1; src_data = $urandom;
    step();
    chk("stop_write", fifo_wrreq, 1);
    chk("stop_idle", state, 0);
    repeat (5) begin src_data = $urandom; step(); end
    stop = 0;

    // Degenerate divider values run at period 2
    div_freq = 0;
    wait_tick("div0_first", 50, n);
    wait_tick("div0_period", 50, n);
    chk("div0_period", n, 2);
    div_freq = 1;
    wait_tick("div1_latch", 50, n);
    wait_tick("div1_period", 50, n);
    chk("div1_period", n, 2);

    // Random traffic
    for (int i = 0; i < 4000; i++) begin
      int r;
      src_data  = $urandom;
      src_valid = ($urandom_range(0, 3) != 0);
      fifo_full = ($urandom_range(0, 15) == 0);
      r = $urandom_range(0, 9);
      if (r == 0)      fifo_used = 12'($urandom_range(4032, 4095));
      else if (r < 3)  fifo_used = 12'($urandom_range(0, 2047));
      else             fifo_used = 12'($urandom_range(2048, 4031));
      if ($urandom_range(0, 31) == 0) pause = ~pause;
      if ($urandom_range(0, 49) == 0) div_freq = $urandom_range(0, 7);
      clr_stats = ($urandom_range(0, 199) == 0);
      stop      = ($urandom_range(0, 249) == 0);
      if ($urandom_range(0, 399) == 0) enable = 0;
      else if (!enable && $urandom_range(0, 7) == 0) enable = 1;
      step();
    end

    clr_stats = 0; stop = 0; pause = 0; enable = 0;
    repeat (4) step();
    chk("queue_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
